// File: rtl/gin_feeder.sv
// gin_feeder: streams source words through a 2-entry FIFO onto a tagged GIN port.
// Build option: define GIN_FEEDER_PERF_EN to add the stall_cycles counter output.
module gin_feeder #(
  parameter int ID_LEN    = 5,
  parameter int ROW_LEN   = 4,
  parameter int VALUE_LEN = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ROW_LEN-1:0]   cfg_rows,
  input  logic [ID_LEN-1:0]    cfg_cols,
  input  logic [ROW_LEN-1:0]   cfg_row_base,
  output logic                 busy,
  output logic                 done,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [VALUE_LEN-1:0] in_data,
  output logic                 enable,
  input  logic                 ready,
  output logic [ROW_LEN-1:0]   row_tag,
  output logic [ID_LEN-1:0]    col_tag,
  output logic [VALUE_LEN-1:0] value
`ifdef GIN_FEEDER_PERF_EN
  ,
  output logic [15:0]          stall_cycles
`endif
);

  localparam int CNT_W = ROW_LEN + ID_LEN;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     total_q, total_d;
  logic [CNT_W-1:0]     acc_q, acc_d;
  logic [CNT_W-1:0]     out_q, out_d;
  logic [ID_LEN-1:0]    cols_q, cols_d;
  logic [ID_LEN-1:0]    col_q, col_d;
  logic [ROW_LEN-1:0]   row_q, row_d;
  logic [VALUE_LEN-1:0] mem_q [2];
  logic [VALUE_LEN-1:0] mem_d [2];
  logic                 wr_ptr_q, wr_ptr_d;
  logic                 rd_ptr_q, rd_ptr_d;
  logic [1:0]           count_q, count_d;
  logic                 push, pop;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    total_d  = total_q;
    acc_d    = acc_q;
    out_d    = out_q;
    cols_d   = cols_q;
    col_d    = col_q;
    row_d    = row_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;

    enable   = (count_q != 2'd0);
    pop      = enable && ready;
    // A full FIFO still takes a word when the head leaves in the same cycle.
    in_ready = (state_q == RUN) && ((count_q != 2'd2) || pop) && (acc_q < total_q);
    push     = in_valid && in_ready;
    busy     = (state_q != IDLE);
    done     = (state_q == FIN);
    value    = enable ? mem_q[rd_ptr_q] : '0;
    row_tag  = enable ? row_q : '0;
    col_tag  = enable ? col_q : '0;

    if (push) begin
      mem_d[wr_ptr_q] = in_data;
      wr_ptr_d        = ~wr_ptr_q;
      acc_d           = acc_q + CNT_W'(1);
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
      out_d    = out_q + CNT_W'(1);
      if (col_q == cols_q - ID_LEN'(1)) begin
        col_d = '0;
        row_d = row_q + ROW_LEN'(1);
      end else begin
        col_d = col_q + ID_LEN'(1);
      end
    end
    count_d = count_q + {1'b0, push} - {1'b0, pop};

    case (state_q)
      IDLE: begin
        if (start) begin
          total_d = CNT_W'(cfg_rows) * CNT_W'(cfg_cols);
          cols_d  = cfg_cols;
          col_d   = '0;
          row_d   = cfg_row_base;
          acc_d   = '0;
          out_d   = '0;
          state_d = (cfg_rows == '0 || cfg_cols == '0) ? FIN : RUN;
        end
      end
      RUN: begin
        if (pop && out_q == total_q - CNT_W'(1)) state_d = FIN;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      total_q  <= '0;
      acc_q    <= '0;
      out_q    <= '0;
      cols_q   <= '0;
      col_q    <= '0;
      row_q    <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      total_q  <= total_d;
      acc_q    <= acc_d;
      out_q    <= out_d;
      cols_q   <= cols_d;
      col_q    <= col_d;
      row_q    <= row_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: FIFO storage is not reset; value is gated by enable, so stale words never escape.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

`ifdef GIN_FEEDER_PERF_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (state_q == IDLE && start) begin
      stall_d = '0;
    end else if (enable && !ready && stall_q != 16'hFFFF) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) stall_q <= '0;
    else     stall_q <= stall_d;
  end

  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_gin_feeder.sv
// tb_gin_feeder: randomized scoreboard bench for gin_feeder; expected tags come from k div/mod cols.
// Define GIN_FEEDER_PERF_EN to also check the stall_cycles output.
module tb_gin_feeder;
  localparam int ID_LEN    = 5;
  localparam int ROW_LEN   = 4;
  localparam int VALUE_LEN = 32;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 start = 1'b0;
  logic [ROW_LEN-1:0]   cfg_rows = '0;
  logic [ID_LEN-1:0]    cfg_cols = '0;
  logic [ROW_LEN-1:0]   cfg_row_base = '0;
  logic                 busy, done, in_ready, enable;
  logic                 in_valid = 1'b0;
  logic [VALUE_LEN-1:0] in_data = '0;
  logic                 ready = 1'b0;
  logic [ROW_LEN-1:0]   row_tag;
  logic [ID_LEN-1:0]    col_tag;
  logic [VALUE_LEN-1:0] value;
`ifdef GIN_FEEDER_PERF_EN
  logic [15:0]          stall_cycles;
`endif

  gin_feeder #(.ID_LEN(ID_LEN), .ROW_LEN(ROW_LEN), .VALUE_LEN(VALUE_LEN)) dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_rows(cfg_rows), .cfg_cols(cfg_cols), .cfg_row_base(cfg_row_base),
    .busy(busy), .done(done),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .enable(enable), .ready(ready),
    .row_tag(row_tag), .col_tag(col_tag), .value(value)
`ifdef GIN_FEEDER_PERF_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int                   row;
    int                   col;
    logic [VALUE_LEN-1:0] val;
  } exp_t;

  exp_t                 exp_q[$];
  logic [VALUE_LEN-1:0] src_q[$];
  int                   checks = 0;
  int                   errors = 0;
  int                   valid_pct = 100;
  int                   ready_pct = 100;
  int                   stall_n = 0;
  int                   pops = 0;
  bit                   done_pending = 1'b0;
  bit                   stall_prev = 1'b0;
  logic [ROW_LEN-1:0]   s_row;
  logic [ID_LEN-1:0]    s_col;
  logic [VALUE_LEN-1:0] s_val;
  exp_t                 mon_e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Source driver and GIN-side ready generator
  initial begin : drv
    bit acc;
    forever begin
      @(negedge clk);
      acc = in_valid && in_ready && !rst;
      @(posedge clk);
      #1;
      if (acc && src_q.size() > 0) void'(src_q.pop_front());
      if (src_q.size() > 0 && $urandom_range(0, 99) < valid_pct) begin
        in_valid = 1'b1;
        in_data  = src_q[0];
      end else begin
        in_valid = 1'b0;
        in_data  = $urandom;
      end
      if (stall_n > 0) begin
        ready = 1'b0;
        stall_n--;
      end else begin
        ready = ($urandom_range(0, 99) < ready_pct);
      end
    end
  end

  // Monitor: compares each GIN transfer against the scoreboard queue
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      check("done", 64'(done), 64'(done_pending));
      done_pending = 1'b0;
      if (stall_prev && enable)
        check("stall_stable", {row_tag, col_tag, value}, {s_row, s_col, s_val});
      if (enable && ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_xfer", 64'(enable), 64'(0));
        end else begin
          mon_e = exp_q.pop_front();
          check("row_tag", 64'(row_tag), 64'(mon_e.row));
          check("col_tag", 64'(col_tag), 64'(mon_e.col));
          check("value", 64'(value), 64'(mon_e.val));
          pops++;
          if (exp_q.size() == 0) done_pending = 1'b1;
        end
      end else if (!enable) begin
        check("idle_zero", {row_tag, col_tag, value}, 64'(0));
      end
      stall_prev = enable && !ready;
      s_row = row_tag;
      s_col = col_tag;
      s_val = value;
    end
  end

  // All calls below start and end at posedge+2.
  task automatic start_job(input int rows, input int cols, input int base, input bit seq);
    logic [VALUE_LEN-1:0] w;
    for (int k = 0; k < rows * cols; k++) begin
      w = seq ? VALUE_LEN'(k + 1) : VALUE_LEN'($urandom);
      src_q.push_back(w);
      exp_q.push_back('{row: (base + k / cols) % (1 << ROW_LEN), col: k % cols, val: w});
    end
    start        = 1'b1;
    cfg_rows     = ROW_LEN'(rows);
    cfg_cols     = ID_LEN'(cols);
    cfg_row_base = ROW_LEN'(base);
    @(posedge clk);
    #2;
    start = 1'b0;
    if (rows == 0 || cols == 0) done_pending = 1'b1;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (cyc < 5000) begin
      @(negedge clk);
      cyc++;
      if (done) break;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL job_timeout: got no done after %0d cycles, expected done", cyc);
      exp_q.delete();
      src_q.delete();
    end
    @(posedge clk);
    #2;
    check("queue_drained", 64'(exp_q.size()), 64'(0));
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int cyc;
    int p0;
    repeat (2) @(posedge clk);
    #2;
    check("reset_outputs", {busy, done, in_ready, enable, row_tag, col_tag, value}, 64'(0));
    rst = 1'b0;
    @(posedge clk);
    #2;

    // Full-speed 2x3 job, base 5, data 1..6
    start_job(2, 3, 5, 1'b1);
    wait_done(cyc);
    check("latency_2x3", 64'(cyc), 64'(8));

    // Row tag wraps 15 -> 0
    start_job(2, 1, 15, 1'b0);
    wait_done(cyc);
    check("latency_2x1", 64'(cyc), 64'(4));

    // Five-cycle GIN stall mid-job
    start_job(2, 3, 0, 1'b0);
    @(posedge clk);
    #2;
    stall_n = 5;
    repeat (5) begin
      @(posedge clk);
      #2;
    end
    check("stall_in_ready", 64'(in_ready), 64'(0));
    check("stall_enable", 64'(enable), 64'(1));
    @(posedge clk);
    #2;
`ifdef GIN_FEEDER_PERF_EN
    check("stall_cycles", 64'(stall_cycles), 64'(5));
`endif
    wait_done(cyc);

    // Empty jobs: cols=0 and rows=0
    start_job(3, 0, 2, 1'b0);
    check("empty_busy", 64'(busy), 64'(1));
`ifdef GIN_FEEDER_PERF_EN
    check("stall_cleared", 64'(stall_cycles), 64'(0));
`endif
    wait_done(cyc);
    check("empty_done_lat", 64'(cyc), 64'(1));
    check("empty_busy_end", 64'(busy), 64'(0));
    start_job(0, 4, 1, 1'b0);
    wait_done(cyc);
    check("rows0_done_lat", 64'(cyc), 64'(1));

    // start during RUN with other cfg is ignored
    start_job(2, 3, 3, 1'b0);
    start        = 1'b1;
    cfg_rows     = 4'd7;
    cfg_cols     = 5'd2;
    cfg_row_base = 4'd9;
    @(posedge clk);
    #2;
    start = 1'b0;
    wait_done(cyc);

    // Reset after three of six transfers
    p0 = pops;
    start_job(2, 3, 1, 1'b0);
    cyc = 0;
    while (pops - p0 < 3 && cyc < 100) begin
      @(posedge clk);
      #2;
      cyc++;
    end
    check("pre_reset_pops", 64'(pops - p0), 64'(3));
    rst = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    exp_q.delete();
    src_q.delete();
    done_pending = 1'b0;
    check("midjob_reset", {busy, done, in_ready, enable, row_tag, col_tag, value}, 64'(0));
    repeat (3) begin
      @(posedge clk);
      #2;
    end
    start_job(2, 3, 1, 1'b1);
    wait_done(cyc);
    check("post_reset_lat", 64'(cyc), 64'(8));

    // Largest job: counters must hold 15*31
    start_job(15, 31, 6, 1'b0);
    wait_done(cyc);
    check("max_job_lat", 64'(cyc), 64'(15 * 31 + 2));

    // Randomized jobs with random valid/ready throttling
    for (int j = 0; j < 10; j++) begin
      valid_pct = $urandom_range(20, 100);
      ready_pct = $urandom_range(20, 100);
      start_job($urandom_range(1, 6), $urandom_range(1, 8), $urandom_range(0, 15), 1'b0);
      wait_done(cyc);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
